// File: rtl/funcion_pkg.sv
// rtl/funcion_pkg.sv - shared states and defaults for the function-block sequencer
package funcion_pkg;

  typedef enum logic [1:0] {REPOSO, APLICA, MUESTRA, FIN} estado_t;

  localparam int          N_DEF        = 3;
  localparam int          DWELL_DEF    = 2;
  localparam logic [7:0]  ESPERADO_DEF = 8'h5C;

endpackage

// File: rtl/contador_permanencia.sv
// rtl/contador_permanencia.sv - loadable down-counter timing how long each vector is held
module contador_permanencia #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carga,
  input  logic [W-1:0] valor,
  output logic         fin_cuenta
);

  logic [W-1:0] r_cuenta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cuenta <= '0;
    end else if (carga) begin
      r_cuenta <= valor;
    end else if (r_cuenta != '0) begin
      r_cuenta <= r_cuenta - 1'b1;
    end
  end

  assign fin_cuenta = (r_cuenta == '0);

endmodule

// File: rtl/secuenciador_funcion.sv
// rtl/secuenciador_funcion.sv - sweeps all input vectors of the function under test and captures its truth table
// FUNCION_VERIFICA_EN adds the fallo/n_fallas comparison against ESPERADO.
module secuenciador_funcion
  import funcion_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DWELL = DWELL_DEF
`ifdef FUNCION_VERIFICA_EN
  ,
  parameter logic [(2**N)-1:0] ESPERADO = (2**N)'(ESPERADO_DEF)
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inicio,
  input  logic                abortar,
  output logic [N-1:0]        vec_o,
  input  logic                z_i,
  output logic                ocupado,
  output logic                listo,
  output logic [(2**N)-1:0]   resultado
`ifdef FUNCION_VERIFICA_EN
  ,
  output logic                fallo,
  output logic [N:0]          n_fallas
`endif
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  estado_t             r_estado;
  estado_t             w_siguiente;
  logic [N-1:0]        r_idx;
  logic [(2**N)-1:0]   r_resultado;
  logic                w_ultimo;
  logic                w_arranca;
  logic                w_muestrea;
  logic                w_carga;
  logic                w_fin_cuenta;

  assign w_ultimo   = (r_idx == N'((2**N) - 1));
  assign w_arranca  = (r_estado == REPOSO) && inicio && !abortar;
  assign w_muestrea = (r_estado == MUESTRA) && !abortar;
  // Reload the dwell counter on every entry into APLICA, from REPOSO or MUESTRA
  assign w_carga    = (w_siguiente == APLICA) && (r_estado != APLICA);

  contador_permanencia #(.W(DW)) u_permanencia (
    .clk        (clk),
    .rst_n      (rst_n),
    .carga      (w_carga),
    .valor      (DW'(DWELL - 1)),
    .fin_cuenta (w_fin_cuenta)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= REPOSO;
    end else begin
      r_estado <= w_siguiente;
    end
  end

  always_comb begin
    w_siguiente = r_estado;
    ocupado     = (r_estado != REPOSO);
    listo       = 1'b0;
    vec_o       = r_idx;
    case (r_estado)
      REPOSO: begin
        vec_o = '0;
        if (inicio) w_siguiente = APLICA;
      end
      APLICA:  if (w_fin_cuenta) w_siguiente = MUESTRA;
      MUESTRA: w_siguiente = w_ultimo ? FIN : APLICA;
      FIN: begin
        listo       = !abortar;
        w_siguiente = REPOSO;
      end
      default: w_siguiente = REPOSO;
    endcase
    if (abortar) w_siguiente = REPOSO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_resultado <= '0;
    end else if (w_arranca) begin
      r_idx       <= '0;
      r_resultado <= '0;
    end else if (w_muestrea) begin
      r_resultado[r_idx] <= z_i;
      if (!w_ultimo) r_idx <= r_idx + 1'b1;
    end
  end

  assign resultado = r_resultado;

`ifdef FUNCION_VERIFICA_EN
  logic [N:0] r_n_fallas;
  logic [N:0] w_n_fallas_sig;
  logic       r_fallo;

  assign w_n_fallas_sig = r_n_fallas + (N+1)'(z_i != ESPERADO[r_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_fallas <= '0;
      r_fallo    <= 1'b0;
    end else if (w_arranca) begin
      r_n_fallas <= '0;
      r_fallo    <= 1'b0;
    end else if (w_muestrea) begin
      r_n_fallas <= w_n_fallas_sig;
      if (w_ultimo) r_fallo <= (w_n_fallas_sig != '0);
    end
  end

  assign fallo    = r_fallo;
  assign n_fallas = r_n_fallas;
`endif

endmodule
